// File: rtl/wm_pkg.sv
// Shared constants and small helpers for the washing-machine plant model.
// The default cycle counts are also used by the controller bench, so a
// change here changes the timing of the whole closed-loop simulation.
package wm_pkg;

    localparam int DEF_FILL_CYCLES = 8;
    localparam int DEF_WASH_CYCLES = 16;
    localparam int DEF_SPIN_CYCLES = 12;
    localparam int DEF_DET_CYCLES  = 3;
    localparam int DEF_CNT_W       = 5;

    // What the water level does this cycle, decoded from the two valves.
    typedef enum logic [1:0] {
        LVL_HOLD     = 2'd0,
        LVL_FILL     = 2'd1,
        LVL_DRAIN    = 2'd2,
        LVL_CONFLICT = 2'd3
    } lvl_op_e;

    function automatic lvl_op_e level_op(input logic fill, input logic drain);
        lvl_op_e op;
        op = LVL_HOLD;
        if (fill && drain) begin
            op = LVL_CONFLICT;
        end else if (fill) begin
            op = LVL_FILL;
        end else if (drain) begin
            op = LVL_DRAIN;
        end
        return op;
    endfunction

endpackage

// File: rtl/wm_phase_timer.sv
// Saturating up-counter with a terminal flag. Clear has priority over
// enable; with neither asserted the count simply holds, which is how the
// top level freezes the timer after a fault.
module wm_phase_timer #(
    parameter int CNT_W = 5,
    parameter int LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             expired
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up until the limit and stick there.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign expired = (cnt_q == LIMIT_C);

endmodule

// File: rtl/wm_plant_model.sv
// Appliance-side model of the washing machine: takes the controller's
// actuator outputs plus user door pulses and produces the sensor inputs
// the controller expects. Illegal actuator combinations latch a sticky
// fault that freezes every piece of state until reset.
module wm_plant_model
    import wm_pkg::*;
#(
    parameter int FILL_CYCLES = DEF_FILL_CYCLES,
    parameter int WASH_CYCLES = DEF_WASH_CYCLES,
    parameter int SPIN_CYCLES = DEF_SPIN_CYCLES,
    parameter int DET_CYCLES  = DEF_DET_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             user_close,
    input  logic             user_open,
    input  logic             door_lock,
    input  logic             motor_on,
    input  logic             fill_value_on,
    input  logic             drain_value_on,
    input  logic             soap_wash,
    input  logic             water_wash,
    input  logic             done,
    output logic             door_close,
    output logic             filled,
    output logic             drained,
    output logic             detergent_added,
    output logic             cycle_timeout,
    output logic             spin_timeout,
    output logic             fault,
    output logic [CNT_W-1:0] level
);

    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(FILL_CYCLES);

    logic             door_q,       door_d;
    logic [CNT_W-1:0] level_q,      level_d;
    logic             fault_q,      fault_d;
    logic             det_flag_q,   det_flag_d;
    logic             soap_prev_q,  soap_prev_d;
    logic             water_prev_q, water_prev_d;

    logic             freeze;
    logic             fault_now;
    logic             soap_rise;
    logic             water_rise;
    lvl_op_e          lvl_op;

    logic             wash_clr, wash_en, wash_expired;
    logic             spin_clr, spin_en, spin_expired;
    logic             det_clr,  det_en,  det_expired;
    logic [CNT_W-1:0] wash_cnt_unused;
    logic [CNT_W-1:0] spin_cnt_unused;
    logic [CNT_W-1:0] det_cnt_unused;

    assign filled  = (level_q == FILL_MAX);
    assign drained = (level_q == '0);

    // Fault detection, edge detection on the wash phases and timer controls.
    // Once the fault is latched every clear/enable is forced low so all
    // timers hold their last value.
    always_comb begin
        freeze     = fault_q;
        fault_now  = (fill_value_on && drain_value_on)
                   || (motor_on && !door_q)
                   || (door_lock && !door_q);
        soap_rise  = soap_wash && !soap_prev_q;
        water_rise = water_wash && !water_prev_q;
        lvl_op     = level_op(fill_value_on, drain_value_on);

        wash_clr = !freeze && (done || !(soap_wash || water_wash) || soap_rise || water_rise);
        wash_en  = !freeze && motor_on && filled && !drain_value_on;
        spin_clr = !freeze && (done || !motor_on || !drain_value_on);
        spin_en  = !freeze && motor_on && drain_value_on && drained;
        det_clr  = !freeze && (done || !soap_wash);
        det_en   = !freeze && soap_wash && filled;
    end

    // Next-state for door, level, fault, detergent flag and phase history.
    always_comb begin
        door_d       = door_q;
        level_d      = level_q;
        fault_d      = fault_q || fault_now;
        det_flag_d   = det_flag_q;
        soap_prev_d  = soap_prev_q;
        water_prev_d = water_prev_q;
        if (!freeze) begin
            if (user_close) begin
                door_d = 1'b1;
            end else if (user_open && !door_lock) begin
                door_d = 1'b0;
            end

            case (lvl_op)
                LVL_FILL: begin
                    if (level_q != FILL_MAX) begin
                        level_d = level_q + CNT_W'(1);
                    end
                end
                LVL_DRAIN: begin
                    if (level_q != '0) begin
                        level_d = level_q - CNT_W'(1);
                    end
                end
                default: level_d = level_q;
            endcase

            if (done) begin
                det_flag_d = 1'b0;
            end else begin
                det_flag_d = det_flag_q || det_expired;
            end

            soap_prev_d  = soap_wash;
            water_prev_d = water_wash;
        end
    end

    // State registers, all returned to the idle/empty state by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            door_q       <= 1'b0;
            level_q      <= '0;
            fault_q      <= 1'b0;
            det_flag_q   <= 1'b0;
            soap_prev_q  <= 1'b0;
            water_prev_q <= 1'b0;
        end else begin
            door_q       <= door_d;
            level_q      <= level_d;
            fault_q      <= fault_d;
            det_flag_q   <= det_flag_d;
            soap_prev_q  <= soap_prev_d;
            water_prev_q <= water_prev_d;
        end
    end

    wm_phase_timer #(.CNT_W(CNT_W), .LIMIT(WASH_CYCLES)) u_wash_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (wash_clr),
        .en      (wash_en),
        .cnt     (wash_cnt_unused),
        .expired (wash_expired)
    );

    wm_phase_timer #(.CNT_W(CNT_W), .LIMIT(SPIN_CYCLES)) u_spin_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (spin_clr),
        .en      (spin_en),
        .cnt     (spin_cnt_unused),
        .expired (spin_expired)
    );

    wm_phase_timer #(.CNT_W(CNT_W), .LIMIT(DET_CYCLES)) u_det_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (det_clr),
        .en      (det_en),
        .cnt     (det_cnt_unused),
        .expired (det_expired)
    );

    // The detergent flag register keeps the sensor high after soap_wash
    // drops; the timer's own flag covers the first cycle it is reached.
    assign detergent_added = det_flag_q || det_expired;
    assign cycle_timeout   = wash_expired;
    assign spin_timeout    = spin_expired;
    assign door_close      = door_q;
    assign fault           = fault_q;
    assign level           = level_q;

endmodule

// File: tb/tb_wm_plant_model.sv
// Directed testbench for the washing-machine plant model.
module tb_wm_plant_model;

    logic       clk;
    logic       reset;
    logic       user_close;
    logic       user_open;
    logic       door_lock;
    logic       motor_on;
    logic       fill_value_on;
    logic       drain_value_on;
    logic       soap_wash;
    logic       water_wash;
    logic       done;
    logic       door_close;
    logic       filled;
    logic       drained;
    logic       detergent_added;
    logic       cycle_timeout;
    logic       spin_timeout;
    logic       fault;
    logic [4:0] level;

    int testsRun;
    int testsFailed;

    wm_plant_model dut (
        .clk             (clk),
        .reset           (reset),
        .user_close      (user_close),
        .user_open       (user_open),
        .door_lock       (door_lock),
        .motor_on        (motor_on),
        .fill_value_on   (fill_value_on),
        .drain_value_on  (drain_value_on),
        .soap_wash       (soap_wash),
        .water_wash      (water_wash),
        .done            (done),
        .door_close      (door_close),
        .filled          (filled),
        .drained         (drained),
        .detergent_added (detergent_added),
        .cycle_timeout   (cycle_timeout),
        .spin_timeout    (spin_timeout),
        .fault           (fault),
        .level           (level)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive the controller-side actuator inputs.
    task automatic applyStimulus(input logic fill, input logic drain, input logic motor,
                                 input logic lock, input logic soap, input logic water,
                                 input logic fin);
        fill_value_on  = fill;
        drain_value_on = drain;
        motor_on       = motor;
        door_lock      = lock;
        soap_wash      = soap;
        water_wash     = water;
        done           = fin;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_level"},   level, 0);
        checkOutput({tag, "_drained"}, drained, 1);
        checkOutput({tag, "_filled"},  filled, 0);
        checkOutput({tag, "_door"},    door_close, 0);
        checkOutput({tag, "_fault"},   fault, 0);
        checkOutput({tag, "_ctmo"},    cycle_timeout, 0);
        checkOutput({tag, "_stmo"},    spin_timeout, 0);
        checkOutput({tag, "_det"},     detergent_added, 0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        user_close  = 1'b0;
        user_open   = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checkResetState("idle");

        // Door: close, locked open ignored, unlocked open works, close wins.
        user_close = 1'b1;
        tick();
        user_close = 1'b0;
        checkOutput("door_closed", door_close, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        user_open = 1'b1;
        tick();
        user_open = 1'b0;
        checkOutput("door_locked_open", door_close, 1);
        tick();
        checkOutput("door_stays", door_close, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        user_open = 1'b1;
        tick();
        user_open = 1'b0;
        checkOutput("door_opened", door_close, 0);
        user_close = 1'b1;
        user_open  = 1'b1;
        tick();
        user_close = 1'b0;
        user_open  = 1'b0;
        checkOutput("door_close_wins", door_close, 1);
        checkOutput("door_no_fault", fault, 0);

        // Fill for 10 cycles: level climbs to 8 and saturates.
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            checkOutput($sformatf("fill_level_%0d", k), level, (k < 8) ? k : 8);
            checkOutput($sformatf("fill_full_%0d", k), filled, (k >= 8) ? 1 : 0);
        end
        // Drain for 8 cycles back to empty, then one more saturates at 0.
        applyStimulus(0, 1, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            checkOutput($sformatf("drain_level_%0d", k), level, (k < 8) ? 8 - k : 0);
            checkOutput($sformatf("drain_empty_%0d", k), drained, (k >= 8) ? 1 : 0);
        end

        // Refill, then soap phase: soap alone one cycle, then motor joins.
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) tick();
        checkOutput("refill_full", filled, 1);
        applyStimulus(0, 0, 0, 1, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 1, 1, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 1) checkOutput("det_before", detergent_added, 0);
            if (k == 2) checkOutput("det_after3", detergent_added, 1);
            if (k == 15) checkOutput("soap_tmo_15", cycle_timeout, 0);
            if (k == 16) checkOutput("soap_tmo_16", cycle_timeout, 1);
            if (k == 17) checkOutput("soap_tmo_hold", cycle_timeout, 1);
        end

        // Changeover to rinse: timer restarts, detergent flag held.
        applyStimulus(0, 0, 1, 1, 0, 1, 0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 1) checkOutput("rinse_tmo_drop", cycle_timeout, 0);
            if (k == 1) checkOutput("rinse_det_held", detergent_added, 1);
            if (k == 16) checkOutput("rinse_tmo_16", cycle_timeout, 0);
            if (k == 17) checkOutput("rinse_tmo_17", cycle_timeout, 1);
        end

        // Drain with motor off, rinse still selected: wash timer holds.
        applyStimulus(0, 1, 0, 1, 0, 1, 0);
        for (int k = 0; k < 8; k++) tick();
        checkOutput("spin_pre_drained", drained, 1);
        checkOutput("spin_pre_ctmo", cycle_timeout, 1);

        // Spin: motor + drain at empty level.
        applyStimulus(0, 1, 1, 1, 0, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 11) checkOutput("spin_tmo_11", spin_timeout, 0);
            if (k == 12) checkOutput("spin_tmo_12", spin_timeout, 1);
        end

        // done clears timers and detergent flag, not level or door.
        applyStimulus(0, 1, 1, 1, 0, 1, 1);
        tick();
        applyStimulus(0, 1, 1, 1, 0, 1, 0);
        checkOutput("done_stmo", spin_timeout, 0);
        checkOutput("done_ctmo", cycle_timeout, 0);
        checkOutput("done_det", detergent_added, 0);
        checkOutput("done_door", door_close, 1);
        checkOutput("done_level", level, 0);

        // Spin again, then asynchronous reset between clock edges.
        for (int k = 0; k < 12; k++) tick();
        checkOutput("respin_tmo", spin_timeout, 1);
        #2;
        reset = 1'b1;
        #1;
        checkResetState("async_rst");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        tick();

        // Fault: both valves together at level 3 freezes everything.
        user_close = 1'b1;
        tick();
        user_close = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick();
        checkOutput("pre_fault_level", level, 3);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        tick();
        checkOutput("valve_fault", fault, 1);
        checkOutput("valve_fault_level", level, 3);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        user_open = 1'b1;
        tick();
        user_open = 1'b0;
        tick();
        checkOutput("frozen_level", level, 3);
        checkOutput("frozen_door", door_close, 1);
        checkOutput("fault_sticky", fault, 1);

        // Fault: motor with door open.
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checkOutput("rst_clears_fault", fault, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        tick();
        checkOutput("motor_door_fault", fault, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("motor_fault_level", level, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/wm_plant_model.md
Name: wm_plant_model

Overview:
- Synthesizable appliance-side model of the washing machine. It is the other end of the controller's actuator/sensor interface.
- Consumes the controller's actuator outputs (door_lock, motor_on, fill/drain valves, soap/water wash, done) and user stimulus.
- Produces the sensor inputs the controller consumes: door_close, filled, detergent_added, cycle_timeout, drained, spin_timeout.
- Used for closed-loop simulation and FPGA demo of the controller, with fault detection on illegal actuator combinations.

Parameters:
- FILL_CYCLES, 8: cycles of fill valve to go from empty to full.
- WASH_CYCLES, 16: motor cycles per wash phase before cycle_timeout.
- SPIN_CYCLES, 12: motor+drain cycles after empty before spin_timeout.
- DET_CYCLES, 3: soap_wash cycles at full level before detergent_added.
- CNT_W, 5: width of all internal counters; must hold the largest *_CYCLES value.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- user_close  in  1  one-cycle pulse: user shuts the door.
- user_open  in  1  one-cycle pulse: user opens the door.
- door_lock  in  1  controller door lock.
- motor_on  in  1  controller motor.
- fill_value_on  in  1  controller fill valve.
- drain_value_on  in  1  controller drain valve.
- soap_wash  in  1  controller soap-wash phase.
- water_wash  in  1  controller rinse phase.
- done  in  1  controller cycle complete.
- door_close  out  1  door shut sensor.
- filled  out  1  level == FILL_CYCLES.
- drained  out  1  level == 0.
- detergent_added  out  1  detergent dispensed sensor.
- cycle_timeout  out  1  wash phase timer expired.
- spin_timeout  out  1  spin timer expired.
- fault  out  1  sticky illegal-actuation flag.
- level  out  CNT_W  water level, for debug.

Behaviour:
- All state is registered and outputs are functions of registers only. Any input affects outputs the following cycle.
- Reset (asynchronous, any time, including mid-cycle) forces:
  - level=0, so drained=1 and filled=0.
  - door_close=0.
  - All timers 0, so cycle_timeout=0 and spin_timeout=0.
  - detergent_added=0, fault=0.
- Door:
  - user_close sets door_close.
  - user_open clears door_close only if door_lock=0; otherwise it is ignored.
  - If both pulses arrive in the same cycle, close wins.
- Level counter:
  - fill only: +1, saturating at FILL_CYCLES.
  - drain only: -1, saturating at 0.
  - Both valves on: level holds and fault is set.
- Wash timer:
  - Clears when neither soap_wash nor water_wash is high.
  - Clears on the cycle after a rising edge of either signal, which covers the soap-to-rinse changeover.
  - Increments while motor_on=1, filled=1 and drain_value_on=0.
  - Saturates at WASH_CYCLES. cycle_timeout = (wash_cnt == WASH_CYCLES) and stays high until the timer clears.
- Spin timer:
  - Clears when motor_on=0 or drain_value_on=0.
  - Increments while motor_on=1, drain_value_on=1 and drained=1.
  - Saturates at SPIN_CYCLES. spin_timeout = (spin_cnt == SPIN_CYCLES).
- Detergent:
  - Det counter increments while soap_wash=1 and filled=1.
  - At DET_CYCLES, detergent_added is set (sticky).
  - Counter and flag clear on done=1. The counter clears when soap_wash=0, but the flag is held.
- Fault (sticky until reset) is set by any of:
  - fill_value_on && drain_value_on
  - motor_on && !door_close
  - door_lock && !door_close
  - Once fault=1, all counters freeze; outputs hold their last values.
- done=1: wash, spin and det counters and detergent_added clear. level and door are unaffected.

Decomposition:
- Package wm_pkg: default cycle constants (FILL/WASH/SPIN/DET) and CNT_W, shared with the controller bench.
- Sub-module wm_phase_timer (ports clk, reset, clr, en, cnt, expired): saturating up-counter with terminal flag, parameter LIMIT.
- wm_phase_timer is instantiated three times: wash, spin, detergent.
- Level counter, door register and fault logic stay in the top module.

Test Plan:
- Reset at t=0, then release, with no stimulus → drained=1, filled=0, door_close=0, fault=0, level=0 held indefinitely.
- user_close pulse, door_lock=1, user_open pulse → door_close=1 and stays 1. Then door_lock=0 plus user_open → door_close=0 next cycle.
- fill_value_on held for 10 cycles → level rises 1..8, filled=1 from cycle 8, level saturates at 8. Then drain_value_on for 8 cycles → drained=1 at cycle 8.
- Full level, soap_wash=1, motor_on=1 → detergent_added=1 after 3 cycles, cycle_timeout=1 after 16 cycles. Switching to water_wash → cycle_timeout drops, re-asserts 16 cycles later.
- From level 0, motor_on=1 and drain_value_on=1 → spin_timeout=1 after 12 cycles. Then done=1 → spin_timeout, cycle_timeout and detergent_added all 0 next cycle.
- fill and drain valves together, or motor_on with door open → fault=1 next cycle, level frozen. Asynchronous reset mid-spin → all outputs return to reset values immediately.
